seg_scan_display: RTL



---
 rtl/seg_scan_display.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_display.sv
// Binary-to-BCD converter (shift-add-3) driving a multiplexed
// common-anode 7-segment display with optional leading-zero blanking.
module seg_scan_display #(
    parameter int REFRESH_N = 18,
    parameter bit BLANK_LZ  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value,
    output logic [11:0] bcd,
    output logic        busy,
    output logic        done,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                state, state_nx;
    logic [19:0]           sr, sr_nx, sr_adj;
    logic [2:0]            cnt, cnt_nx;
    logic [7:0]            last, last_nx;
    logic [REFRESH_N-1:0]  refresh;
    logic [1:0]            sel;
    logic [3:0]            an_nx;
    logic [6:0]            seg_nx;
    logic [3:0]            hund, tens, ones;
    logic                  blank_h, blank_t;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign sr_adj = {add3(sr[19:16]), add3(sr[15:12]),
                     add3(sr[11:8]), sr[7:0]};

    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = cnt;
        last_nx  = last;
        unique case (state)
            IDLE: begin
                if (value != last) begin
                    sr_nx    = {12'b0, value};
                    cnt_nx   = 3'd0;
                    last_nx  = value;
                    state_nx = CONV;
                end
            end
            CONV: begin
                sr_nx  = {sr_adj[18:0], 1'b0};
                cnt_nx = cnt + 3'd1;
                if (cnt == 3'd7)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            last  <= '0;
            bcd   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            sr    <= sr_nx;
            cnt   <= cnt_nx;
            last  <= last_nx;
            done  <= (state == DONE);
            if (state == DONE)
                bcd <= sr[19:8];
        end
    end

    assign busy = (state == CONV);
    assign dp   = 1'b1;

    assign sel  = refresh[REFRESH_N-1 -: 2];
    assign hund = bcd[11:8];
    assign tens = bcd[7:4];
    assign ones = bcd[3:0];

    // Tens only blanks when the hundreds digit is blank too
    assign blank_h = BLANK_LZ && (hund == 4'd0);
    assign blank_t = blank_h && (tens == 4'd0);

    always_comb begin
        an_nx  = 4'b1111;
        seg_nx = 7'h7F;
        unique case (sel)
            2'd0: begin
                an_nx  = 4'b1110;
                seg_nx = enc(ones);
            end
            2'd1: begin
                an_nx  = 4'b1101;
                seg_nx = blank_t ? 7'h7F : enc(tens);
            end
            2'd2: begin
                an_nx  = 4'b1011;
                seg_nx = blank_h ? 7'h7F : enc(hund);
            end
            2'd3: begin
                an_nx  = 4'b1111;
                seg_nx = 7'h7F;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh <= '0;
            an      <= 4'b1111;
            seg     <= 7'h7F;
        end else begin
            refresh <= refresh + REFRESH_N'(1);
            an      <= an_nx;
            seg     <= seg_nx;
        end
    end

endmodule
